hist_decompressor_nch: RTL and testbench



---
 rtl/hist_decomp_pkg.sv | 35 +++
 rtl/lfsr_galois.sv | 24 ++
 rtl/hist_decompressor_nch.sv | 114 +++++++++++
 tb/tb_hist_decompressor_nch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hist_decomp_pkg.sv
// Shared types and helpers for the N-stream histogram decompressor.
package hist_decomp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int MAX_BINS = 16;

  function automatic int num_bins(input int num_streams);
    return 1 << num_streams;
  endfunction

  // A sum of 2^ns values of cnt_w bits needs ns extra bits to never overflow.
  function automatic int sum_width(input int cnt_w, input int num_streams);
    return cnt_w + num_streams;
  endfunction

  // First set bit of nz at or after position first, wrapping modulo nbins.
  function automatic int select_bin(input logic [MAX_BINS-1:0] nz, input int first,
                                    input int nbins);
    int   idx;
    int   result;
    logic found;
    result = 0;
    found  = 1'b0;
    for (int i = 0; i < MAX_BINS; i++) begin
      idx = (first + i) % nbins;
      if (!found && i < nbins && nz[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR; load (reseed) wins over step.
module lfsr_galois #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/hist_decompressor_nch.sv
// Rebuilds NUM_STREAMS correlated unary bitstreams from a joint histogram,
// emitting one joint symbol per accepted beat in LFSR-shuffled order.
module hist_decompressor_nch
  import hist_decomp_pkg::*;
#(
  parameter int                NUM_STREAMS   = 2,
  parameter int                STREAM_LENGTH = 128,
  parameter int                CNT_W         = $clog2(STREAM_LENGTH + 1),
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [num_bins(NUM_STREAMS)*CNT_W-1:0] counts,
  output logic                                  busy,
  output logic                                  err,
  output logic [NUM_STREAMS-1:0]                out_bits,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  done
);

  localparam int NUM_BINS = num_bins(NUM_STREAMS);
  localparam int SUM_W    = sum_width(CNT_W, NUM_STREAMS);

  state_t                   state;
  logic [CNT_W-1:0]         cnt [NUM_BINS];
  logic [CNT_W-1:0]         remaining;
  logic [SUM_W-1:0]         sum;
  logic [MAX_BINS-1:0]      nz;
  logic [NUM_STREAMS-1:0]   sel_idx;
  logic [LFSR_W-1:0]        lfsr_q;
  logic                     slot_free;
  logic                     sum_ok;
  logic                     lfsr_load;
  logic                     lfsr_step;

  always_comb begin
    sum = '0;
    nz  = '0;
    for (int b = 0; b < NUM_BINS; b++) begin
      sum   = sum + SUM_W'(counts[b*CNT_W +: CNT_W]);
      nz[b] = (cnt[b] != '0);
    end
  end

  // Scan starts at the LFSR's low bits; modulo NUM_BINS keeps only those bits.
  assign sel_idx   = NUM_STREAMS'(select_bin(nz, int'(lfsr_q), NUM_BINS));
  assign sum_ok    = (sum == SUM_W'(STREAM_LENGTH));
  assign slot_free = !out_valid || out_ready;
  assign lfsr_load = (state == IDLE) && start && sum_ok;
  assign lfsr_step = (state == RUN) && slot_free;
  assign busy      = (state != IDLE);

  lfsr_galois #(
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (LFSR_TAPS),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      out_bits  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      for (int b = 0; b < NUM_BINS; b++) cnt[b] <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (sum_ok) begin
              for (int b = 0; b < NUM_BINS; b++) cnt[b] <= counts[b*CNT_W +: CNT_W];
              remaining <= CNT_W'(STREAM_LENGTH);
              state     <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (slot_free) begin
            out_bits     <= sel_idx;
            out_valid    <= 1'b1;
            cnt[sel_idx] <= cnt[sel_idx] - CNT_W'(1);
            remaining    <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_decompressor_nch.sv
// Randomised self-checking bench for hist_decompressor_nch (2- and 3-stream builds).
module tb_hist_decompressor_nch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        out_ready;
  logic        sel3;
  logic [15:0] counts2;
  logic [39:0] counts3;
  logic        busy2, err2, out_valid2, done2;
  logic [1:0]  out_bits2;
  logic        busy3, err3, out_valid3, done3;
  logic [2:0]  out_bits3;
  logic        start2, start3;
  logic        obs_busy, obs_err, obs_valid, obs_done;
  logic [2:0]  obs_bits;

  int cnts [16];
  int vectors = 0;
  int miscompares = 0;
  int expq [$];

  always #5 clk = ~clk;

  always_comb begin
    counts2 = '0;
    counts3 = '0;
    for (int b = 0; b < 4; b++) counts2[b*4 +: 4] = 4'(cnts[b]);
    for (int b = 0; b < 8; b++) counts3[b*5 +: 5] = 5'(cnts[b]);
  end

  assign start2    = start & ~sel3;
  assign start3    = start & sel3;
  assign obs_busy  = sel3 ? busy3 : busy2;
  assign obs_err   = sel3 ? err3 : err2;
  assign obs_valid = sel3 ? out_valid3 : out_valid2;
  assign obs_done  = sel3 ? done3 : done2;
  assign obs_bits  = sel3 ? out_bits3 : {1'b0, out_bits2};

  hist_decompressor_nch #(.NUM_STREAMS(2), .STREAM_LENGTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .counts(counts2), .busy(busy2),
    .err(err2), .out_bits(out_bits2), .out_valid(out_valid2),
    .out_ready(out_ready), .done(done2)
  );

  hist_decompressor_nch #(.NUM_STREAMS(3), .STREAM_LENGTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .counts(counts3), .busy(busy3),
    .err(err3), .out_bits(out_bits3), .out_valid(out_valid3),
    .out_ready(out_ready), .done(done3)
  );

  task automatic check_output(input string tag, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference order: scan bins from (lfsr mod bins) for the first non-empty one.
  task automatic build_expected(input int ns, input int len);
    int w [16];
    int v, nb, r, pick, b;
    nb = 1 << ns;
    v  = 'hACE1;
    expq.delete();
    for (int i = 0; i < 16; i++) w[i] = cnts[i];
    for (int n = 0; n < len; n++) begin
      r    = v % nb;
      pick = -1;
      for (int i = 0; i < nb; i++) begin
        b = (r + i) % nb;
        if (pick < 0 && w[b] > 0) pick = b;
      end
      if (pick < 0) pick = 0;
      w[pick]--;
      expq.push_back(pick);
      v = (v % 2 == 1) ? ((v / 2) ^ 'hB400) : (v / 2);
    end
  endtask

  task automatic apply_stimulus(input int ns, input int len, input int ready_mode,
                                input int abort_after, input string tag);
    int ones [3];
    int exp_ones [3];
    int accepted, cycles, held;
    bit stall_prev;
    sel3 = (ns == 3);
    build_expected(ns, len);
    for (int k = 0; k < 3; k++) begin
      ones[k]     = 0;
      exp_ones[k] = 0;
      for (int b = 0; b < (1 << ns); b++)
        if (((b >> k) & 1) == 1) exp_ones[k] += cnts[b];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output({tag, " busy_after_start"}, int'(obs_busy), 1);
    check_output({tag, " valid_not_yet"}, int'(obs_valid), 0);
    @(posedge clk); #1;
    check_output({tag, " first_valid"}, int'(obs_valid), 1);
    accepted   = 0;
    cycles     = 0;
    held       = 0;
    stall_prev = 1'b0;
    while (accepted < len && cycles < 400) begin
      if (stall_prev) check_output({tag, " stall_stable"}, int'(obs_bits), held);
      if (accepted == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_output({tag, " rst_busy"}, int'(obs_busy), 0);
        check_output({tag, " rst_valid"}, int'(obs_valid), 0);
        check_output({tag, " rst_bits"}, int'(obs_bits), 0);
        check_output({tag, " rst_done"}, int'(obs_done), 0);
        repeat (2) @(posedge clk);
        #1;
        check_output({tag, " rst_err"}, int'(obs_err), 0);
        rst_n = 1'b1;
        return;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cycles % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (obs_valid && out_ready) begin
        check_output({tag, " symbol"}, int'(obs_bits), expq[accepted]);
        for (int k = 0; k < ns; k++) ones[k] += (int'(obs_bits) >> k) & 1;
        accepted++;
        stall_prev = 1'b0;
      end else begin
        stall_prev = obs_valid;
        held       = int'(obs_bits);
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (accepted < len) begin
      check_output({tag, " timeout_accepted"}, accepted, len);
    end else begin
      check_output({tag, " done_pulse"}, int'(obs_done), 1);
      check_output({tag, " busy_at_done"}, int'(obs_busy), 0);
      check_output({tag, " valid_at_done"}, int'(obs_valid), 0);
      for (int k = 0; k < ns; k++) check_output({tag, " stream_ones"}, ones[k], exp_ones[k]);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check_output({tag, " done_one_cycle"}, int'(obs_done), 0);
    end
  endtask

  task automatic check_reject(input string tag);
    sel3  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output({tag, " err_pulse"}, int'(obs_err), 1);
    check_output({tag, " busy"}, int'(obs_busy), 0);
    check_output({tag, " valid"}, int'(obs_valid), 0);
    check_output({tag, " done"}, int'(obs_done), 0);
    @(posedge clk); #1;
    check_output({tag, " err_cleared"}, int'(obs_err), 0);
    check_output({tag, " still_idle"}, int'(obs_busy), 0);
  endtask

  task automatic random_counts(input int nb, input int len);
    int idx;
    for (int b = 0; b < 16; b++) cnts[b] = 0;
    for (int n = 0; n < len; n++) begin
      idx = $urandom_range(0, nb - 1);
      cnts[idx]++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    sel3      = 1'b0;
    for (int b = 0; b < 16; b++) cnts[b] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel3 = (d == 1);
      #1;
      check_output("reset busy", int'(obs_busy), 0);
      check_output("reset err", int'(obs_err), 0);
      check_output("reset valid", int'(obs_valid), 0);
      check_output("reset bits", int'(obs_bits), 0);
      check_output("reset done", int'(obs_done), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    cnts[0] = 8;
    apply_stimulus(2, 8, 0, -1, "single_bin");

    for (int b = 0; b < 4; b++) cnts[b] = 2;
    apply_stimulus(2, 8, 0, -1, "flat");
    apply_stimulus(2, 8, 1, -1, "flat_toggle");

    cnts[0] = 3; cnts[1] = 2; cnts[2] = 2; cnts[3] = 0;
    check_reject("short_sum");

    cnts[0] = 1; cnts[1] = 2; cnts[2] = 3; cnts[3] = 2;
    apply_stimulus(2, 8, 0, 3, "abort");
    apply_stimulus(2, 8, 0, -1, "rerun");

    for (int t = 0; t < 6; t++) begin
      random_counts(4, 8);
      apply_stimulus(2, 8, 2, -1, "random2");
    end

    random_counts(4, 8);
    idx = $urandom_range(0, 3);
    cnts[idx]++;
    check_reject("long_sum");

    for (int b = 0; b < 16; b++) cnts[b] = (b < 8) ? 2 : 0;
    apply_stimulus(3, 16, 0, -1, "flat3");

    for (int t = 0; t < 3; t++) begin
      random_counts(8, 16);
      apply_stimulus(3, 16, 2, -1, "random3");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
